// File: rtl/shared_reg_pkg.sv
// rtl/shared_reg_pkg.sv - shared register arbiter defaults and FSM state type
package shared_reg_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_MAXHOLD = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set req bit at or above ptr, wrapping
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to ptr is the last one assigned.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin ownership of one shared register with hold limit
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int MAXHOLD = DEF_MAXHOLD
) (
  input  logic                 c,
  input  logic                 r,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         wr,
  input  logic [N*W-1:0]       d,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [W-1:0]         q
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAXHOLD + 1);

  state_t        state, state_n;
  logic [N-1:0]  gnt_n;
  logic [IW-1:0] owner_n, ptr, ptr_n, win, owner_inc;
  logic [HW-1:0] hold, hold_n;
  logic [W-1:0]  q_n;
  logic          found, wr_en, release_now;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (win)
  );

  assign owner_inc   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
  // A write on the forced-release edge still lands; only req/wr/gnt of the owner qualify it.
  assign wr_en       = (state == OWN) && req[owner] && wr[owner] && gnt[owner];
  assign release_now = !req[owner] || (hold == HW'(MAXHOLD));
  assign busy        = (state == OWN);

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold;
    q_n     = wr_en ? d[owner*W +: W] : q;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = OWN;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          owner_n    = win;
          hold_n     = HW'(1);
        end
      end
      OWN: begin
        if (release_now) begin
          state_n = IDLE;
          gnt_n   = '0;
          owner_n = '0;
          ptr_n   = owner_inc;
          hold_n  = '0;
        end else if (hold != HW'(MAXHOLD)) begin
          hold_n = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      hold  <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      hold  <= hold_n;
      q     <= q_n;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

  logic        c = 1'b0;
  logic        r = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  wr = '0;
  logic [31:0] d = '0;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [7:0]  q;

  shared_reg_arbiter dut (
    .c     (c),
    .r     (r),
    .req   (req),
    .wr    (wr),
    .d     (d),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  always #5 c = ~c;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic       m_busy = 1'b0;
  int         m_owner = 0;
  int         m_ptr = 0;
  int         m_hold = 0;
  logic [7:0] m_q = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int i, input logic [7:0] b);
    logic [31:0] v;
    v = '0;
    v[i*8 +: 8] = b;
    return v;
  endfunction

  task automatic model_step(input logic rr, input logic [3:0] rq, input logic [3:0] w,
                            input logic [31:0] dv);
    exp_t e;
    if (rr) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0; m_q = '0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && rq[(m_ptr + k) % 4]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % 4;
          m_hold  = 1;
        end
      end
    end else begin
      if (rq[m_owner] && w[m_owner]) m_q = dv[m_owner*8 +: 8];
      if (!rq[m_owner] || m_hold == 8) begin
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = 0;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
    e.gnt   = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    e.owner = 2'(m_owner);
    e.busy  = m_busy;
    e.q     = m_q;
    sb.push_back(e);
  endtask

  // One clock: drive, predict, sample 1 time unit after the edge, compare.
  task automatic cyc(input logic rr, input logic [3:0] rq, input logic [3:0] w,
                     input logic [31:0] dv);
    exp_t e;
    r = rr; req = rq; wr = w; d = dv;
    model_step(rr, rq, w, dv);
    @(posedge c);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_gnt", 32'(gnt), 32'(e.gnt));
      check("sb_owner", 32'(owner), 32'(e.owner));
      check("sb_busy", 32'(busy), 32'(e.busy));
      check("sb_q", 32'(q), 32'(e.q));
    end
  endtask

  initial begin
    int gcount;
    logic [7:0] dv;

    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_q", 32'(q), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // single request: grant after edge 1, write lands at edge 2
    cyc(1'b0, 4'b0001, 4'b0001, slice(0, 8'hA5));
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_no_early_wr", 32'(q), 32'h0);
    cyc(1'b0, 4'b0001, 4'b0001, slice(0, 8'hA5));
    check("single_q", 32'(q), 32'hA5);
    cyc(1'b0, 4'b0000, 4'b0000, '0);
    check("single_release", 32'(gnt), 32'h0);

    // round robin from ptr 0
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1111, 4'b0000, '0);
      check("rr_order", 32'(gnt), 32'(4'b0001 << (k % 4)));
      cyc(1'b0, 4'b1111, 4'b0000, '0);
      cyc(1'b0, 4'b1111 & ~(4'b0001 << (k % 4)), 4'b0000, '0);
      check("rr_gap", 32'(gnt), 32'h0);
    end

    // non-owner write ignored
    cyc(1'b1, 4'b0000, 4'b0000, '0);
    cyc(1'b0, 4'b0010, 4'b0010, slice(1, 8'h77));
    check("nonown_gnt", 32'(gnt), 32'h2);
    cyc(1'b0, 4'b0010, 4'b0010, slice(1, 8'h77));
    check("nonown_setup_q", 32'(q), 32'h77);
    cyc(1'b0, 4'b1010, 4'b1000, slice(3, 8'h3C));
    check("nonown_q", 32'(q), 32'h77);
    cyc(1'b0, 4'b0000, 4'b0010, slice(1, 8'h11));
    check("own_wr_noreq_q", 32'(q), 32'h77);

    // forced release: requester 2 alone for 12 cycles
    gcount = 0;
    for (int e = 0; e < 12; e++) begin
      dv = 8'h20 + 8'(e);
      cyc(1'b0, 4'b0100, 4'b0100, slice(2, dv));
      if (gnt[2]) gcount++;
      if (e >= 1 && e <= 8) check("force_q", 32'(q), 32'(dv));
      if (e == 8) check("force_idle", 32'(gnt), 32'h0);
      if (e == 9) check("force_regrant", 32'(gnt), 32'h4);
    end
    check("force_gnt_cycles", 32'(gcount), 32'd11);
    cyc(1'b0, 4'b0000, 4'b0000, '0);

    // wrap search from ptr 3
    cyc(1'b0, 4'b0011, 4'b0000, '0);
    check("wrap_winner", 32'(gnt), 32'h1);
    cyc(1'b0, 4'b0000, 4'b0000, '0);

    // reset mid-ownership (ptr is 1 here)
    cyc(1'b0, 4'b0001, 4'b0000, '0);
    check("midrst_own", 32'(gnt), 32'h1);
    cyc(1'b1, 4'b0001, 4'b0001, slice(0, 8'h55));
    check("midrst_q", 32'(q), 32'h0);
    check("midrst_gnt", 32'(gnt), 32'h0);
    cyc(1'b0, 4'b1111, 4'b0000, '0);
    check("midrst_ptr0", 32'(gnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
